// File: rtl/itcm_arbiter.sv
// Single-port ITCM arbiter: fetch, LSU and debug share a 1-cycle-latency SRAM.
// Read responses are steered back to the issuing requester via a registered owner tag.
module itcm_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ITCM_AW      = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,

    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  instr_read_data_valid,
    output logic [DATA_WIDTH-1:0] instr_read_data,

    input  logic                  dmem_req,
    input  logic                  dmem_we,
    input  logic [3:0]            dmem_be,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_rdata_valid,
    output logic [DATA_WIDTH-1:0] dmem_rdata,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rdata_valid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,

    output logic                  itcm_en,
    output logic                  itcm_we,
    output logic [3:0]            itcm_be,
    output logic [ITCM_AW-1:0]    itcm_addr,
    output logic [DATA_WIDTH-1:0] itcm_wdata,
    input  logic [DATA_WIDTH-1:0] itcm_rdata,

    output logic [31:0]           fetch_stall_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DMEM  = 2'd2,
        OWN_DBG   = 2'd3
    } owner_t;

    owner_t     owner_r;
    logic [3:0] starve_cnt;

    logic boost;
    logic fetch_win;
    logic dmem_win;
    logic dbg_win;
    logic fetch_denied;

    // Boost lets a starved fetch pre-empt both debug and LSU for one grant.
    assign boost        = fetch_req && (starve_cnt == 4'(STARVE_LIMIT));
    assign fetch_win    = fetch_req && (boost || (!dbg_req && !dmem_req));
    assign dbg_win      = dbg_req && !boost;
    assign dmem_win     = dmem_req && !dbg_req && !boost;
    assign fetch_denied = fetch_req && !fetch_win;

    assign dmem_gnt = dmem_win;
    assign dbg_gnt  = dbg_win;

    always_comb begin
        itcm_en    = 1'b0;
        itcm_we    = 1'b0;
        itcm_be    = '0;
        itcm_addr  = '0;
        itcm_wdata = '0;
        if (fetch_win) begin
            itcm_en   = 1'b1;
            itcm_be   = 4'hF;
            itcm_addr = fetch_addr[ITCM_AW+1:2];
        end else if (dbg_win) begin
            itcm_en    = 1'b1;
            itcm_we    = dbg_we;
            itcm_be    = 4'hF;
            itcm_addr  = dbg_addr[ITCM_AW+1:2];
            itcm_wdata = dbg_wdata;
        end else if (dmem_win) begin
            itcm_en    = 1'b1;
            itcm_we    = dmem_we;
            itcm_be    = dmem_be;
            itcm_addr  = dmem_addr[ITCM_AW+1:2];
            itcm_wdata = dmem_wdata;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            owner_r         <= OWN_NONE;
            starve_cnt      <= '0;
            fetch_stall_cnt <= '0;
        end else begin
            if (fetch_win)
                owner_r <= OWN_FETCH;
            else if (dbg_win && !dbg_we)
                owner_r <= OWN_DBG;
            else if (dmem_win && !dmem_we)
                owner_r <= OWN_DMEM;
            else
                owner_r <= OWN_NONE;

            if (fetch_denied) begin
                if (starve_cnt != 4'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 4'd1;
                fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign instr_read_data_valid = (owner_r == OWN_FETCH);
    assign dmem_rdata_valid      = (owner_r == OWN_DMEM);
    assign dbg_rdata_valid       = (owner_r == OWN_DBG);

    assign instr_read_data = instr_read_data_valid ? itcm_rdata : '0;
    assign dmem_rdata      = dmem_rdata_valid      ? itcm_rdata : '0;
    assign dbg_rdata       = dbg_rdata_valid       ? itcm_rdata : '0;

    // Address bits outside the ITCM word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[ADDR_WIDTH-1:ITCM_AW+2], fetch_addr[1:0],
                                dmem_addr[ADDR_WIDTH-1:ITCM_AW+2],  dmem_addr[1:0],
                                dbg_addr[ADDR_WIDTH-1:ITCM_AW+2],   dbg_addr[1:0]};

endmodule

// File: tb/tb_itcm_arbiter.sv
// Directed bench for itcm_arbiter: SRAM model plus a read-response scoreboard.
module tb_itcm_arbiter;

    localparam int LIMIT = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rdata_valid;
    logic [31:0] dmem_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rdata_valid;
    logic [31:0] dbg_rdata;
    logic        itcm_en, itcm_we;
    logic [3:0]  itcm_be;
    logic [13:0] itcm_addr;
    logic [31:0] itcm_wdata;
    logic [31:0] itcm_rdata;
    logic [31:0] fetch_stall_cnt;

    itcm_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ITCM_AW(14), .STARVE_LIMIT(LIMIT)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rdata_valid(dmem_rdata_valid),
        .dmem_rdata(dmem_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata_valid(dbg_rdata_valid), .dbg_rdata(dbg_rdata),
        .itcm_en(itcm_en), .itcm_we(itcm_we), .itcm_be(itcm_be), .itcm_addr(itcm_addr),
        .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata),
        .fetch_stall_cnt(fetch_stall_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] pat(input logic [13:0] a);
        return 32'hC0DE_0000 ^ {18'h0, a};
    endfunction

    // SRAM model: read data one cycle after issue, a poison word otherwise.
    always @(posedge cpu_clk)
        itcm_rdata <= (itcm_en && !itcm_we) ? pat(itcm_addr) : 32'hBAD0_BAD0;

    typedef struct {
        int          who;   // 0 fetch, 1 dmem, 2 dbg
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int who, input logic [13:0] a);
        exp_t e;
        e.who  = who;
        e.data = pat(a);
        sb.push_back(e);
    endtask

    task automatic check_resp();
        logic [2:0]  vexp;
        logic [31:0] d0, d1, d2;
        exp_t        e;
        vexp = '0; d0 = '0; d1 = '0; d2 = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vexp[e.who] = 1'b1;
            if (e.who == 0) d0 = e.data;
            else if (e.who == 1) d1 = e.data;
            else d2 = e.data;
        end
        chk("instr_valid", {31'h0, instr_read_data_valid}, {31'h0, vexp[0]});
        chk("dmem_valid",  {31'h0, dmem_rdata_valid},      {31'h0, vexp[1]});
        chk("dbg_valid",   {31'h0, dbg_rdata_valid},       {31'h0, vexp[2]});
        chk("instr_data",  instr_read_data, d0);
        chk("dmem_data",   dmem_rdata, d1);
        chk("dbg_data",    dbg_rdata, d2);
    endtask

    task automatic idle();
        fetch_req = 1'b0; fetch_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_be = '0; dmem_addr = '0; dmem_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
        check_resp();
    endtask

    initial begin
        idle();
        cpu_rstn = 1'b0;
        #12;
        // Reset state
        chk("rst_en", {31'h0, itcm_en}, 32'h0);
        chk("rst_stall", fetch_stall_cnt, 32'h0);
        check_resp();
        @(posedge cpu_clk); #1;
        cpu_rstn = 1'b1;
        tick();

        // Sequential fetch stream
        for (int unsigned i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'h100 + 32'(4 * i);
            #1;
            chk("fetch_en",   {31'h0, itcm_en}, 32'h1);
            chk("fetch_we",   {31'h0, itcm_we}, 32'h0);
            chk("fetch_be",   {28'h0, itcm_be}, 32'hF);
            chk("fetch_addr", {18'h0, itcm_addr}, 32'h40 + 32'(i));
            push(0, 14'h40 + 14'(i));
            tick();
        end
        idle(); #1;
        chk("idle_en", {31'h0, itcm_en}, 32'h0);
        chk("idle_wdata", itcm_wdata, 32'h0);
        tick();
        chk("stall0", fetch_stall_cnt, 32'h0);

        // fetch and dmem collide: dmem wins
        fetch_req = 1'b1; fetch_addr = 32'h180;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_be = 4'hF; dmem_addr = 32'h200;
        #1;
        chk("col_dmem_gnt", {31'h0, dmem_gnt}, 32'h1);
        chk("col_addr", {18'h0, itcm_addr}, 32'h80);
        push(1, 14'h80);
        tick();
        idle();
        chk("stall1", fetch_stall_cnt, 32'h1);
        tick();

        // Held dmem vs fetch: fetch boosted every fifth cycle
        for (int unsigned i = 0; i < 10; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'h110;
            dmem_req = 1'b1; dmem_we = 1'b0; dmem_be = 4'hF; dmem_addr = 32'h204;
            #1;
            if (i % 5 == 4) begin
                chk("starve_dmem_gnt", {31'h0, dmem_gnt}, 32'h0);
                chk("starve_addr", {18'h0, itcm_addr}, 32'h44);
                push(0, 14'h44);
            end else begin
                chk("starve_dmem_gnt", {31'h0, dmem_gnt}, 32'h1);
                chk("starve_addr", {18'h0, itcm_addr}, 32'h81);
                push(1, 14'h81);
            end
            tick();
        end
        idle();
        chk("stall9", fetch_stall_cnt, 32'd9);
        tick();

        // Debug write beats concurrent LSU write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hDEADBEEF;
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'h3; dmem_addr = 32'h300; dmem_wdata = 32'h12345678;
        #1;
        chk("dbgw_gnt",   {31'h0, dbg_gnt},  32'h1);
        chk("dbgw_dgnt",  {31'h0, dmem_gnt}, 32'h0);
        chk("dbgw_we",    {31'h0, itcm_we},  32'h1);
        chk("dbgw_be",    {28'h0, itcm_be},  32'hF);
        chk("dbgw_addr",  {18'h0, itcm_addr}, 32'h10);
        chk("dbgw_wdata", itcm_wdata, 32'hDEADBEEF);
        tick();
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        chk("dmw_gnt",   {31'h0, dmem_gnt}, 32'h1);
        chk("dmw_be",    {28'h0, itcm_be},  32'h3);
        chk("dmw_addr",  {18'h0, itcm_addr}, 32'hC0);
        chk("dmw_wdata", itcm_wdata, 32'h12345678);
        tick();
        idle();
        tick();

        // Debug read then back-to-back LSU read
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_be = 4'hF; dmem_addr = 32'h208;
        #1;
        chk("dbgr_gnt", {31'h0, dbg_gnt}, 32'h1);
        chk("dbgr_addr", {18'h0, itcm_addr}, 32'h11);
        push(2, 14'h11);
        tick();
        dbg_req = 1'b0;
        #1;
        chk("b2b_gnt", {31'h0, dmem_gnt}, 32'h1);
        chk("b2b_addr", {18'h0, itcm_addr}, 32'h82);
        push(1, 14'h82);
        tick();
        idle();
        tick();

        // Reset while a fetch read is outstanding
        fetch_req = 1'b1; fetch_addr = 32'h120;
        #1;
        chk("rfetch_en", {31'h0, itcm_en}, 32'h1);
        cpu_rstn = 1'b0;
        sb.delete();
        tick();
        chk("rmid_stall", fetch_stall_cnt, 32'h0);
        idle();
        cpu_rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/itcm_arbiter.md
Name: itcm_arbiter

Overview:
Arbitrates a single-port, 1-cycle-latency ITCM SRAM between three requesters: the instruction fetch stage, the LSU data port (loads/stores into the ITCM region) and the debug/system-bus program loader. It issues at most one access per cycle and tags reads so the returned word goes back to the right requester. Fetch starvation is bounded, and fetch stalls are counted. Fetch sees a lost arbitration as a cycle with instr_read_data_valid low, which the fetch stage already treats as a bubble/keep-pc condition.

Parameters:
ADDR_WIDTH, 32, byte address width of all requester address ports
DATA_WIDTH, 32, data/instruction word width
ITCM_AW, 14, SRAM word-address width; ITCM size is 4*2^ITCM_AW bytes
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch gets top priority for one grant (1..15)

Ports:
cpu_clk  in  1  core clock
cpu_rstn  in  1  reset
fetch_req  in  1  fetch read request (next_pc valid)
fetch_addr  in  ADDR_WIDTH  fetch byte address (next_pc)
instr_read_data_valid  out  1  fetch read data valid
instr_read_data  out  DATA_WIDTH  fetched instruction
dmem_req  in  1  LSU request, held until dmem_gnt
dmem_we  in  1  LSU write
dmem_be  in  4  LSU byte enables
dmem_addr  in  ADDR_WIDTH  LSU byte address
dmem_wdata  in  DATA_WIDTH  LSU write data
dmem_gnt  out  1  LSU request accepted this cycle
dmem_rdata_valid  out  1  LSU read data valid
dmem_rdata  out  DATA_WIDTH  LSU read data
dbg_req  in  1  debug request, held until dbg_gnt
dbg_we  in  1  debug write (full word)
dbg_addr  in  ADDR_WIDTH  debug byte address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_gnt  out  1  debug request accepted
dbg_rdata_valid  out  1  debug read data valid
dbg_rdata  out  DATA_WIDTH  debug read data
itcm_en  out  1  SRAM chip enable
itcm_we  out  1  SRAM write enable
itcm_be  out  4  SRAM byte enables
itcm_addr  out  ITCM_AW  SRAM word address
itcm_wdata  out  DATA_WIDTH  SRAM write data
itcm_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after a read is issued
fetch_stall_cnt  out  32  performance counter of denied fetch cycles

Behaviour:
- Reset: cpu_rstn, asynchronous, active-low; clock cpu_clk. All registered state clears: owner_r=NONE, starve_cnt=0, fetch_stall_cnt=0. Consequently all *_valid outputs are 0 and all *_rdata/instr_read_data are 0.
- Arbitration is combinational in the request cycle, with at most one grant per cycle:
  - Normal priority: dbg > dmem > fetch.
  - Boost: if starve_cnt==STARVE_LIMIT and fetch_req, fetch wins over both dbg and dmem.
- Grants: dmem_gnt/dbg_gnt are asserted in the cycle their access is issued on the SRAM. Fetch has no grant port; a fetch grant is internal (fetch_win).
- SRAM drive:
  - itcm_en=1 on any grant, otherwise 0.
  - itcm_addr = winner addr[ITCM_AW+1:2]; addr[1:0] is ignored (fetch misalignment is handled upstream).
  - Fetch: we=0, be=4'hF.
  - dmem: we=dmem_we, be=dmem_be.
  - dbg: we=dbg_we, be=4'hF.
  - itcm_wdata comes from the winner, or 0 if there is none.
- Read tagging: owner_r <= FETCH/DMEM/DBG when the issued access is a read, else NONE. In the cycle after issue, the tagged requester's valid=1 and its data port = itcm_rdata. Non-owners' data ports are 0. Read latency is exactly 1 cycle.
- Writes produce no response pulse; the grant is the completion.
- starve_cnt: if fetch_req && !fetch_win, increment, saturating at STARVE_LIMIT. Otherwise (fetch granted, or fetch_req low) clear to 0.
- fetch_stall_cnt: +1 every cycle with fetch_req && !fetch_win; wraps modulo 2^32.
- Back-to-back: a new access may be issued in the same cycle a previous read's data returns; there is no bubble.
- Reset mid-read: a pending response is dropped and no valid pulse is produced.
- Requests with all reqs low: itcm_en=0, and owner_r becomes NONE next cycle.

Test Plan:
- Fetch only, fetch_addr=0x100..0x10C sequential -> itcm_addr=0x40..0x43 on consecutive cycles; instr_read_data_valid=1 each following cycle with matching itcm_rdata; fetch_stall_cnt=0.
- fetch_req + dmem_req read at 0x200 in the same cycle -> dmem_gnt=1, itcm_addr=0x80; next cycle dmem_rdata_valid=1, instr_read_data_valid=0, fetch_stall_cnt=1.
- dmem_req held continuously with fetch_req, STARVE_LIMIT=4 -> fetch denied 4 cycles, granted on the 5th (dmem_gnt=0 that cycle), starve_cnt back to 0; the pattern repeats.
- dbg write 0xDEADBEEF to 0x40 concurrent with a dmem write -> dbg wins: itcm_we=1, be=4'hF, addr=0x10; dmem granted the next cycle; no rdata_valid pulses.
- Fetch read issued, then cpu_rstn asserted before the next edge -> instr_read_data_valid stays 0, owner_r=NONE, counters 0.
